// File: rtl/ula_video_monitor.sv
// ULA video output monitor: measures line and frame timing,
// checksums each frame and reports timing lock.
module ula_video_monitor #(
   parameter int LOCK_FRAMES = 2,
   parameter int SUM_W       = 24
) (
   input  logic             clk_sys,
   input  logic             reset,
   input  logic             ce_vid,
   input  logic             HSync,
   input  logic             VSync,
   input  logic             HBlank,
   input  logic [2:0]       Rx,
   input  logic [2:0]       Gx,
   input  logic [2:0]       Bx,
   output logic [9:0]       line_len,
   output logic [6:0]       hs_width,
   output logic [8:0]       frame_lines,
   output logic [3:0]       vs_lines,
   output logic [SUM_W-1:0] frame_sum,
   output logic             frame_valid,
   output logic             locked,
   output logic             err
);

   typedef enum logic [1:0] {
      SEARCH,
      MEASURE,
      LOCKED
   } state_t;

   state_t           state;
   logic             hs_p;
   logic             vs_p;
   logic [9:0]       pc;
   logic [6:0]       hs_cnt;
   logic [8:0]       lc;
   logic [3:0]       vc;
   logic [SUM_W-1:0] sum;
   logic [9:0]       ref_len;
   logic [8:0]       ref_lines;
   logic [3:0]       ref_vs;
   logic [3:0]       match;

   logic             hs_rise;
   logic             hs_fall;
   logic             vs_rise;
   logic [9:0]       pc_inc;
   logic [9:0]       len_n;
   logic [SUM_W-1:0] sum_n;
   logic [3:0]       match_n;
   logic             same_ref;
   logic             sat_err;
   logic             lock_err;

   assign hs_rise = HSync & ~hs_p;
   assign hs_fall = ~HSync & hs_p;
   assign vs_rise = VSync & ~vs_p;
   assign pc_inc  = (pc == 10'd1023) ? pc : pc + 10'd1;
   assign len_n   = hs_rise ? pc_inc : line_len;
   assign sum_n   = sum + ((HBlank | VSync) ? '0
                                            : SUM_W'({Rx, Gx, Bx}));

   // Frame-end compare sees the line length updated on this sample
   assign same_ref = (len_n == ref_len) && (lc == ref_lines)
                     && (vc == ref_vs);
   assign match_n  = same_ref ? match + 4'd1 : 4'd1;
   assign sat_err  = (hs_rise && pc == 10'd1023)
                     || (vs_rise && lc == 9'd511);
   assign lock_err = (state == LOCKED)
                     && ((hs_rise && pc_inc != ref_len)
                         || (vs_rise && (lc != ref_lines
                                         || vc != ref_vs)));

   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         state       <= SEARCH;
         hs_p        <= 1'b0;
         vs_p        <= 1'b0;
         pc          <= '0;
         hs_cnt      <= '0;
         lc          <= '0;
         vc          <= '0;
         sum         <= '0;
         ref_len     <= '0;
         ref_lines   <= '0;
         ref_vs      <= '0;
         match       <= '0;
         line_len    <= '0;
         hs_width    <= '0;
         frame_lines <= '0;
         vs_lines    <= '0;
         frame_sum   <= '0;
         frame_valid <= 1'b0;
         locked      <= 1'b0;
         err         <= 1'b0;
      end else begin
         frame_valid <= 1'b0;
         if (ce_vid) begin
            hs_p     <= HSync;
            vs_p     <= VSync;
            pc       <= hs_rise ? 10'd0 : pc_inc;
            line_len <= len_n;
            if (HSync)
               hs_cnt <= (hs_cnt == 7'd127) ? hs_cnt : hs_cnt + 7'd1;
            else
               hs_cnt <= 7'd0;
            if (hs_fall)
               hs_width <= hs_cnt;
            if (vs_rise) begin
               lc  <= {8'd0, hs_rise};
               vc  <= {3'd0, hs_rise};
               sum <= '0;
            end else begin
               sum <= sum_n;
               if (hs_rise && lc != 9'd511)
                  lc <= lc + 9'd1;
               if (hs_rise && VSync && vc != 4'd15)
                  vc <= vc + 4'd1;
            end
            if (vs_rise && state != SEARCH) begin
               frame_lines <= lc;
               vs_lines    <= vc;
               frame_sum   <= sum_n;
               frame_valid <= 1'b1;
            end
            if (sat_err || lock_err) begin
               state  <= SEARCH;
               locked <= 1'b0;
               err    <= 1'b1;
            end else begin
               unique case (state)
                  SEARCH: begin
                     if (vs_rise) begin
                        state     <= MEASURE;
                        match     <= '0;
                        ref_len   <= '0;
                        ref_lines <= '0;
                        ref_vs    <= '0;
                     end
                  end
                  MEASURE: begin
                     if (vs_rise) begin
                        match <= match_n;
                        if (!same_ref) begin
                           ref_len   <= len_n;
                           ref_lines <= lc;
                           ref_vs    <= vc;
                        end
                        if (match_n >= 4'(LOCK_FRAMES)) begin
                           state  <= LOCKED;
                           locked <= 1'b1;
                        end
                     end
                  end
                  LOCKED: begin
                  end
                  default: state <= SEARCH;
               endcase
            end
         end
      end
   end

endmodule

// File: tb/tb_ula_video_monitor.sv
// Bench for ula_video_monitor: synthetic video frames with
// random colours and clock-enable gaps against a frame model.
module tb_ula_video_monitor;

   localparam int LOCK_FRAMES = 2;
   localparam int SUM_W       = 24;

   logic             clk_sys = 1'b0;
   logic             reset;
   logic             ce_vid;
   logic             HSync;
   logic             VSync;
   logic             HBlank;
   logic [2:0]       Rx;
   logic [2:0]       Gx;
   logic [2:0]       Bx;
   logic [9:0]       line_len;
   logic [6:0]       hs_width;
   logic [8:0]       frame_lines;
   logic [3:0]       vs_lines;
   logic [SUM_W-1:0] frame_sum;
   logic             frame_valid;
   logic             locked;
   logic             err;

   int checks = 0;
   int passes = 0;
   int fv_cnt = 0;
   int fv_long = 0;
   logic fv_prev = 1'b0;
   int base;

   int L, W, N, V, AX0, AW, AY0, AH;
   bit cmode, gaps;
   logic [SUM_W-1:0] acc, exp_sum;

   ula_video_monitor #(
      .LOCK_FRAMES(LOCK_FRAMES),
      .SUM_W(SUM_W)
   ) dut (
      .clk_sys(clk_sys),
      .reset(reset),
      .ce_vid(ce_vid),
      .HSync(HSync),
      .VSync(VSync),
      .HBlank(HBlank),
      .Rx(Rx),
      .Gx(Gx),
      .Bx(Bx),
      .line_len(line_len),
      .hs_width(hs_width),
      .frame_lines(frame_lines),
      .vs_lines(vs_lines),
      .frame_sum(frame_sum),
      .frame_valid(frame_valid),
      .locked(locked),
      .err(err)
   );

   always #5 clk_sys = ~clk_sys;

   always @(posedge clk_sys) begin
      if (frame_valid)
         fv_cnt <= fv_cnt + 1;
      if (frame_valid && fv_prev)
         fv_long <= fv_long + 1;
      fv_prev <= frame_valid;
   end

   task automatic put(input logic hs, input logic vs,
                      input logic hb, input logic [8:0] rgb);
      HSync  = hs;
      VSync  = vs;
      HBlank = hb;
      {Rx, Gx, Bx} = rgb;
      ce_vid = 1'b1;
      @(negedge clk_sys);
      ce_vid = 1'b0;
      if (gaps && $urandom_range(0, 7) == 0) begin
         {HSync, VSync, HBlank, Rx, Gx, Bx} = 12'($urandom);
         @(negedge clk_sys);
      end
   endtask

   task automatic idle();
      ce_vid = 1'b0;
      @(negedge clk_sys);
   endtask

   task automatic set_geom(input int l, input int w, input int n,
                           input int v, input int ax0, input int aw,
                           input int ay0, input int ah,
                           input bit cm, input bit g);
      L = l; W = w; N = n; V = v;
      AX0 = ax0; AW = aw; AY0 = ay0; AH = ah;
      cmode = cm; gaps = g;
   endtask

   task automatic drive_line(input int y, input int x0, input int x1);
      logic vs, hb;
      logic [8:0] rgb;
      for (int x = x0; x < x1; x++) begin
         vs  = y < V;
         hb  = !(x >= AX0 && x < AX0 + AW && y >= AY0 && y < AY0 + AH);
         rgb = cmode ? 9'h1FF : 9'($urandom);
         if (!hb && !vs)
            acc = acc + SUM_W'(rgb);
         put(x < W, vs, hb, rgb);
      end
   endtask

   task automatic frame_start();
      exp_sum = acc;
      acc = '0;
   endtask

   task automatic drive_frame();
      frame_start();
      for (int y = 0; y < N; y++)
         drive_line(y, 0, L);
   endtask

   task automatic do_reset();
      @(negedge clk_sys);
      reset = 1'b1;
      ce_vid = 1'b0;
      {HSync, VSync, HBlank, Rx, Gx, Bx} = '0;
      @(negedge clk_sys);
      @(negedge clk_sys);
      reset = 1'b0;
      acc = '0;
      exp_sum = '0;
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if ({line_len, hs_width, frame_lines, vs_lines, frame_sum} !== '0)
         $display("FAIL reset_outputs: got %h want 0",
                  {line_len, hs_width, frame_lines, vs_lines, frame_sum});
      else passes++;
      checks++;
      if ({frame_valid, locked, err} !== 3'b000)
         $display("FAIL reset_flags: got %b want 000",
                  {frame_valid, locked, err});
      else passes++;
   endtask

   task automatic test_timing(input int l, input int w);
      do_reset();
      set_geom(l, w, 3, 1, 48, 256, 1, 2, 1'b0, 1'b1);
      base = fv_cnt;
      for (int k = 0; k < 4; k++) begin
         drive_frame();
         checks++;
         if (line_len !== 10'(L))
            $display("FAIL line_len: got %0d want %0d", line_len, L);
         else passes++;
         checks++;
         if (hs_width !== 7'(W))
            $display("FAIL hs_width: got %0d want %0d", hs_width, W);
         else passes++;
         checks++;
         if (locked !== (k >= LOCK_FRAMES) || err !== 1'b0)
            $display("FAIL lock_seq%0d: got locked=%b err=%b want %b/0",
                     k, locked, err, k >= LOCK_FRAMES);
         else passes++;
         if (k >= 1) begin
            checks++;
            if (frame_lines !== 9'(N) || vs_lines !== 4'(V))
               $display("FAIL frame_counts: got %0d/%0d want %0d/%0d",
                        frame_lines, vs_lines, N, V);
            else passes++;
            checks++;
            if (frame_sum !== exp_sum)
               $display("FAIL frame_sum: got %0d want %0d",
                        frame_sum, exp_sum);
            else passes++;
         end
      end
      idle();
      checks++;
      if (fv_cnt - base != 3)
         $display("FAIL fv_count: got %0d want 3", fv_cnt - base);
      else passes++;
   endtask

   task automatic test_short_line();
      test_timing(448, 32);
      base = fv_cnt;
      frame_start();
      drive_line(0, 0, L);
      drive_line(1, 0, L - 1);
      drive_line(2, 0, 1);
      checks++;
      if (line_len !== 10'd447 || err !== 1'b1 || locked !== 1'b0)
         $display("FAIL short_line: got len=%0d err=%b lk=%b want 447/1/0",
                  line_len, err, locked);
      else passes++;
      drive_line(2, 1, L);
      for (int r = 0; r < 3; r++) begin
         drive_frame();
         checks++;
         if (locked !== (r >= LOCK_FRAMES) || err !== 1'b1)
            $display("FAIL relock%0d: got locked=%b err=%b want %b/1",
                     r, locked, err, r >= LOCK_FRAMES);
         else passes++;
         if (r >= 1) begin
            checks++;
            if (frame_sum !== exp_sum)
               $display("FAIL relock_sum: got %0d want %0d",
                        frame_sum, exp_sum);
            else passes++;
         end
      end
      idle();
      checks++;
      if (fv_cnt - base != 3)
         $display("FAIL relock_fv: got %0d want 3", fv_cnt - base);
      else passes++;
   endtask

   task automatic test_frame_312();
      do_reset();
      set_geom(20, 3, 312, 8, 4, 12, 10, 290, 1'b0, 1'b1);
      drive_frame();
      frame_start();
      drive_line(0, 0, 1);
      checks++;
      if (frame_lines !== 9'd312 || vs_lines !== 4'd8)
         $display("FAIL lines312: got %0d/%0d want 312/8",
                  frame_lines, vs_lines);
      else passes++;
      checks++;
      if (frame_sum !== exp_sum)
         $display("FAIL sum312: got %0d want %0d", frame_sum, exp_sum);
      else passes++;
      checks++;
      if (line_len !== 10'd20 || hs_width !== 7'd3)
         $display("FAIL geom312: got %0d/%0d want 20/3",
                  line_len, hs_width);
      else passes++;
   endtask

   task automatic test_checksum();
      do_reset();
      set_geom(256, 4, 193, 1, 0, 256, 1, 192, 1'b1, 1'b0);
      drive_frame();
      frame_start();
      drive_line(0, 0, 1);
      checks++;
      if (frame_sum !== 24'd8339456)
         $display("FAIL checksum_wrap: got %0d want 8339456", frame_sum);
      else passes++;
      checks++;
      if (frame_lines !== 9'd193 || err !== 1'b0)
         $display("FAIL checksum_lines: got %0d err=%b want 193/0",
                  frame_lines, err);
      else passes++;
   endtask

   task automatic test_pc_saturation();
      do_reset();
      gaps = 1'b1;
      put(1'b1, 1'b1, 1'b1, 9'd0);
      for (int i = 0; i < 1100; i++)
         put(1'b0, 1'b0, 1'b1, 9'd0);
      checks++;
      if (line_len !== 10'd1 || err !== 1'b0)
         $display("FAIL pc_stuck: got len=%0d err=%b want 1/0",
                  line_len, err);
      else passes++;
      put(1'b1, 1'b0, 1'b1, 9'd0);
      checks++;
      if (line_len !== 10'd1023 || err !== 1'b1 || locked !== 1'b0)
         $display("FAIL pc_sat: got len=%0d err=%b want 1023/1",
                  line_len, err);
      else passes++;
      idle();
      base = fv_cnt;
      put(1'b0, 1'b0, 1'b1, 9'd0);
      put(1'b0, 1'b1, 1'b1, 9'd0);
      idle();
      idle();
      checks++;
      if (fv_cnt - base != 0 || frame_lines !== 9'd0)
         $display("FAIL pc_search: got fv=%0d fl=%0d want 0/0",
                  fv_cnt - base, frame_lines);
      else passes++;
   endtask

   task automatic test_lc_saturation();
      do_reset();
      set_geom(2, 1, 515, 1, 0, 2, 1, 600, 1'b0, 1'b1);
      drive_frame();
      frame_start();
      drive_line(0, 0, 1);
      checks++;
      if (err !== 1'b1 || locked !== 1'b0)
         $display("FAIL lc_sat: got err=%b locked=%b want 1/0",
                  err, locked);
      else passes++;
      idle();
      idle();
      base = fv_cnt;
      drive_line(0, 1, L);
      for (int y = 1; y < 4; y++)
         drive_line(y, 0, L);
      frame_start();
      drive_line(0, 0, 1);
      idle();
      idle();
      checks++;
      if (fv_cnt - base != 0)
         $display("FAIL lc_search: got fv=%0d want 0", fv_cnt - base);
      else passes++;
   endtask

   task automatic test_reset_midframe();
      do_reset();
      set_geom(20, 3, 4, 1, 2, 14, 1, 3, 1'b0, 1'b1);
      drive_frame();
      drive_frame();
      drive_line(0, 0, L);
      drive_line(1, 0, 7);
      checks++;
      if (frame_lines !== 9'd4)
         $display("FAIL pre_reset: got %0d want 4", frame_lines);
      else passes++;
      {HSync, VSync, HBlank, Rx, Gx, Bx} = 12'($urandom);
      ce_vid = 1'b1;
      #2 reset = 1'b1;
      #1;
      checks++;
      if ({line_len, hs_width, frame_lines, vs_lines, frame_sum,
           frame_valid, locked, err} !== '0)
         $display("FAIL async_reset: got %h want 0",
                  {line_len, hs_width, frame_lines, vs_lines, frame_sum});
      else passes++;
      @(negedge clk_sys);
      {HSync, VSync, HBlank, Rx, Gx, Bx} = 12'($urandom);
      @(negedge clk_sys);
      checks++;
      if ({line_len, frame_lines, frame_sum, locked, err} !== '0)
         $display("FAIL held_reset: got %h want 0",
                  {line_len, frame_lines, frame_sum, locked, err});
      else passes++;
      reset = 1'b0;
      ce_vid = 1'b0;
      acc = '0;
      idle();
      base = fv_cnt;
      drive_frame();
      idle();
      checks++;
      if (fv_cnt - base != 0)
         $display("FAIL first_vs: got fv=%0d want 0", fv_cnt - base);
      else passes++;
      drive_frame();
      idle();
      checks++;
      if (fv_cnt - base != 1 || frame_lines !== 9'd4)
         $display("FAIL second_vs: got fv=%0d fl=%0d want 1/4",
                  fv_cnt - base, frame_lines);
      else passes++;
   endtask

   initial begin
      reset = 1'b1;
      ce_vid = 1'b0;
      {HSync, VSync, HBlank, Rx, Gx, Bx} = '0;
      acc = '0;
      exp_sum = '0;
      gaps = 1'b0;
      test_reset();
      test_short_line();
      test_timing(456, 40);
      test_frame_312();
      test_checksum();
      test_pc_saturation();
      test_lc_saturation();
      test_reset_midframe();
      checks++;
      if (fv_long != 0)
         $display("FAIL fv_pulse_width: got %0d long pulses want 0",
                  fv_long);
      else passes++;
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/ula_video_monitor.md
Name: ula_video_monitor

Overview:
- Receiver/checker at the far end of the ULA video output interface.
- Samples HSync/VSync/HBlank/RGB on the ULA pixel clock enable.
- Measures line length, sync widths and lines per frame, and computes a per-frame pixel checksum.
- Declares lock when timing is stable. Used in the ULA benches and as a debug tap on the video path.

Parameters:
- LOCK_FRAMES, 2, number of consecutive identical-timing frames required to assert locked (1..15).
- SUM_W, 24, width of the frame pixel checksum.

Ports:
- clk_sys  in  1  master clock
- reset  in  1  asynchronous active-high reset
- ce_vid  in  1  pixel clock enable (7 MHz); all sampling happens only when high
- HSync  in  1  horizontal sync, active high
- VSync  in  1  vertical sync, active high
- HBlank  in  1  horizontal blank, active high
- Rx, Gx, Bx  in  3 each  pixel colour
- line_len  out  10  pixel samples between the last two HSync rising edges
- hs_width  out  7  HSync high length in samples, last line
- frame_lines  out  9  HSync rising edges in the last complete frame
- vs_lines  out  4  HSync rising edges seen while VSync high, last frame
- frame_sum  out  SUM_W  checksum of the last complete frame
- frame_valid  out  1  one-clk_sys pulse when frame_* outputs update
- locked  out  1  timing stable
- err  out  1  sticky timing error, cleared only by reset

Behaviour:
- Reset (async): all outputs and counters 0, FSM = SEARCH, and the edge-detect history registers are 0.
- Sampling: on a clk_sys edge with ce_vid=1, register the inputs. An input rise means the current sample is 1 and the previous sample was 0. Nothing changes when ce_vid=0.
- Pixel counter pc (10-bit):
  - Increments on every sample and saturates at 1023.
  - On HSync rise, line_len <= pc + 1 (the sample count including the current one, saturating at 1023), then pc <= 0.
- HSync width counter:
  - Counts samples while HSync=1, saturating at 127.
  - On HSync fall, hs_width <= count, then the count resets.
- Line counter lc (9-bit, saturating):
  - Increments on HSync rise.
  - vc increments on an HSync rise while VSync=1, saturating at 15.
- Checksum:
  - On each sample with HBlank=0 and VSync=0, sum <= sum + {Rx,Gx,Bx}. The 9-bit value is zero-extended and the add wraps modulo 2^SUM_W.
- Frame end (VSync rise):
  - frame_lines <= lc, vs_lines <= vc, frame_sum <= sum (including the current sample's contribution).
  - frame_valid pulses on the next clk_sys.
  - lc restarts at 1 if HSync also rises on this sample, otherwise 0; vc and sum restart the same way.
  - The first VSync rise after reset or after a return to SEARCH captures nothing and does not pulse frame_valid.
- FSM states SEARCH, MEASURE, LOCKED:
  - SEARCH -> MEASURE on a VSync rise; clears the match count and reference values.
  - MEASURE, on each frame end: if line_len, frame_lines and vs_lines equal the stored reference, the match count increments; otherwise the reference is reloaded and the match count becomes 1. When the match count reaches LOCK_FRAMES -> LOCKED, locked=1.
  - LOCKED: any HSync rise with line_len differing from the reference, or a frame end with frame_lines/vs_lines differing -> SEARCH, locked=0, err=1.
  - Any state: pc saturated at 1023 on HSync rise, or lc saturated at 511 on VSync rise -> SEARCH, err=1.
- Simultaneous events: when a line end and a frame end fall on the same sample, the line-end update happens first and the frame-end comparison uses the new line_len.
- Latency: all outputs update on the clk_sys edge following the sampling edge. locked drops on the same edge that err sets.

Test Plan:
- 48K timing (448 samples/line, HSync 32 samples, 312 lines, VSync 8 lines), 4 frames:
  - line_len=448, hs_width=32, frame_lines=312, vs_lines=8.
  - locked=1 after the 3rd VSync rise with LOCK_FRAMES=2; err=0.
- 128K timing (456/line, 311 lines):
  - line_len=456, frame_lines=311, locked after the same frame count.
- Constant colour 3'b111 on all three channels, 256 non-blank samples per line on 192 lines, everything else blank:
  - frame_sum = 511×256×192 mod 2^24 = 25,116,672 mod 16,777,216 = 8,339,456.
- In LOCKED, one line shortened to 447 samples:
  - err=1 and locked=0 on that HSync rise; relock after 2 good frames while err stays 1.
- HSync stuck low for more than 1023 samples, then a rise:
  - line_len=1023, err=1, state SEARCH.
- Reset asserted mid-frame with ce_vid active:
  - all outputs 0 immediately.
  - After release, the first VSync rise gives no frame_valid; the second gives frame_valid=1.
